// File: rtl/zxuno_audio_pkg.sv
// Shared audio definitions for the I2S receive and transmit paths.
package zxuno_audio_pkg;

    // Serial framing state: hunting for a word boundary, or receiving slots.
    typedef enum logic {
        SYNC = 1'b0,
        RECV = 1'b1
    } i2s_state_e;

    // Slot bit counter width; saturates at all-ones.
    localparam int BITCNT_W = 6;
    localparam logic [BITCNT_W-1:0] BITCNT_MAX = '1;

    // LRCLK level for each channel.
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_adc_receiver_sync_edge.sv
// 2-FF synchroniser for an asynchronous strobe line plus data lines, with a
// registered rising-edge detect on the strobe. Data lines are only synchronised.
module sync_edge #(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_edge,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_rise
);

    logic [1:0]        r_edge_sync;
    logic              r_edge_prev;
    logic              r_rise;
    logic [DATA_W-1:0] r_data_meta;
    logic [DATA_W-1:0] r_data_sync;

    // Two-stage synchronisers; the edge pulse is registered (3 clk input latency).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_sync <= '0;
            r_edge_prev <= 1'b0;
            r_rise      <= 1'b0;
            r_data_meta <= '0;
            r_data_sync <= '0;
        end else begin
            r_edge_sync <= {r_edge_sync[0], i_edge};
            r_edge_prev <= r_edge_sync[1];
            r_rise      <= r_edge_sync[1] & ~r_edge_prev;
            r_data_meta <= i_data;
            r_data_sync <= r_data_meta;
        end
    end

    assign o_data = r_data_sync;
    assign o_rise = r_rise;

endmodule

// File: rtl/i2s_adc_receiver.sv
// Slave-mode Philips I2S receiver: deserialises stereo slots into signed
// WIDTH-bit samples, pulses sample_valid per complete L+R frame, and derives
// a hysteresis tape level from the left channel.
module i2s_adc_receiver
    import zxuno_audio_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int EAR_THRESH = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i2s_sclk,
    input  logic                    i2s_lrclk,
    input  logic                    i2s_sdin,
    output logic signed [WIDTH-1:0] left,
    output logic signed [WIDTH-1:0] right,
    output logic                    sample_valid,
    output logic                    ear_level,
    output logic                    frame_err
);

    localparam logic [BITCNT_W:0]     W_N   = (BITCNT_W+1)'(WIDTH);
    localparam logic signed [WIDTH:0] THR_P = (WIDTH+1)'(EAR_THRESH);
    localparam logic signed [WIDTH:0] THR_N = -THR_P;

    logic [1:0] w_sync;
    logic       w_sedge;
    logic       w_lr;
    logic       w_d;

    sync_edge #(.DATA_W(2)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_edge (i2s_sclk),
        .i_data ({i2s_lrclk, i2s_sdin}),
        .o_data (w_sync),
        .o_rise (w_sedge)
    );

    assign w_lr = w_sync[1];
    assign w_d  = w_sync[0];

    i2s_state_e r_state;
    i2s_state_e w_state_nxt;

    logic                    r_lr_prev;
    logic [BITCNT_W-1:0]     r_bitcnt;
    logic [WIDTH-1:0]        r_shift;
    logic [WIDTH-1:0]        r_left_hold;
    logic                    r_have_left;
    logic signed [WIDTH-1:0] r_left;
    logic signed [WIDTH-1:0] r_right;
    logic                    r_valid;
    logic                    r_ear;
    logic                    r_err;

    logic                    w_clr;
    logic                    w_shift_en;
    logic                    w_slot_end;
    logic                    w_overrun;
    logic [WIDTH-1:0]        w_shift_nxt;
    logic [BITCNT_W:0]       w_nbits;
    logic [WIDTH-1:0]        w_word;
    logic [BITCNT_W-1:0]     w_bitcnt_inc;
    logic signed [WIDTH:0]   w_left_ext;
    logic                    w_ear_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= SYNC;
        else     r_state <= w_state_nxt;
    end

    // Framing FSM: decides per SCLK edge whether to shift, close a slot or abort.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift_en  = 1'b0;
        w_slot_end  = 1'b0;
        w_overrun   = 1'b0;
        if (w_sedge) begin
            case (r_state)
                SYNC: begin
                    // First LRCLK transition marks a slot boundary; the partial slot is dropped.
                    if (w_lr != r_lr_prev) begin
                        w_state_nxt = RECV;
                        w_clr       = 1'b1;
                    end
                end
                RECV: begin
                    // An LRCLK change wins over a saturated counter on the same edge.
                    if (w_lr != r_lr_prev) begin
                        w_slot_end = 1'b1;
                        w_clr      = 1'b1;
                    end else if (r_bitcnt == BITCNT_MAX) begin
                        w_overrun   = 1'b1;
                        w_state_nxt = SYNC;
                        w_clr       = 1'b1;
                    end else begin
                        w_shift_en = 1'b1;
                    end
                end
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    // Word assembly: bits past WIDTH are dropped, short slots are left-justified.
    always_comb begin
        w_shift_nxt  = ({1'b0, r_bitcnt} < W_N) ? {r_shift[WIDTH-2:0], w_d} : r_shift;
        w_nbits      = {1'b0, r_bitcnt} + 1'b1;
        w_word       = (w_nbits < W_N) ? (w_shift_nxt << (W_N - w_nbits)) : w_shift_nxt;
        w_bitcnt_inc = (r_bitcnt == BITCNT_MAX) ? r_bitcnt : r_bitcnt + 1'b1;
    end

    // Hysteresis comparator on the left word about to be published, WIDTH+1 bits signed.
    always_comb begin
        w_left_ext = $signed({r_left_hold[WIDTH-1], r_left_hold});
        w_ear_nxt  = r_ear;
        if (w_left_ext > THR_P)      w_ear_nxt = 1'b1;
        else if (w_left_ext < THR_N) w_ear_nxt = 1'b0;
    end

    // Datapath: shift register, hold/output registers, strobe and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lr_prev   <= 1'b0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_have_left <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
            r_ear       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_sedge) r_lr_prev <= w_lr;

            if (w_clr) begin
                r_bitcnt <= '0;
                r_shift  <= '0;
            end else if (w_shift_en) begin
                r_shift  <= w_shift_nxt;
                r_bitcnt <= w_bitcnt_inc;
            end

            if (w_slot_end) begin
                if (r_lr_prev == CH_LEFT) begin
                    r_left_hold <= w_word;
                    r_have_left <= 1'b1;
                end else if (r_have_left) begin
                    // Only publish a right word that follows a fully received left word.
                    r_left  <= r_left_hold;
                    r_right <= w_word;
                    r_valid <= 1'b1;
                    r_ear   <= w_ear_nxt;
                end
            end

            if (w_overrun) begin
                r_err       <= 1'b1;
                r_have_left <= 1'b0;
            end
        end
    end

    assign left         = r_left;
    assign right        = r_right;
    assign sample_valid = r_valid;
    assign ear_level    = r_ear;
    assign frame_err    = r_err;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Self-checking bench for i2s_adc_receiver: directed I2S frames plus random
// frames, checked against a slot-level model of expected samples.
module tb_i2s_adc_receiver;

    localparam int W  = 16;
    localparam int TH = 512;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sclk = 1'b0;
    logic                lrclk = 1'b0;
    logic                sdin = 1'b0;
    logic signed [W-1:0] left;
    logic signed [W-1:0] right;
    logic                sv;
    logic                ear;
    logic                ferr;

    i2s_adc_receiver #(.WIDTH(W), .EAR_THRESH(TH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i2s_sclk     (sclk),
        .i2s_lrclk    (lrclk),
        .i2s_sdin     (sdin),
        .left         (left),
        .right        (right),
        .sample_valid (sv),
        .ear_level    (ear),
        .frame_err    (ferr)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   hp     = 4;
    logic pend   = 1'b0;
    logic m_ear  = 1'b0;
    logic prev_v = 1'b0;

    logic [W-1:0] q_l[$], q_r[$];
    logic         q_e[$];
    logic [W-1:0] e_l[$], e_r[$];
    logic         e_e[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture every published sample; a strobe must never last two clocks.
    always @(negedge clk) begin
        if (sv) begin
            q_l.push_back(left);
            q_r.push_back(right);
            q_e.push_back(ear);
            check("valid_single_cycle", {63'd0, prev_v}, 64'd0);
        end
        prev_v <= sv;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    // Expected WIDTH-bit word from an n-bit slot: keep MSBs, zero-pad short slots.
    function automatic logic [W-1:0] exp_word(input logic [63:0] raw, input int n);
        logic [63:0] m;
        m = raw & ((64'd1 << n) - 64'd1);
        if (n >= W) return W'(m >> (n - W));
        else        return W'(m << (W - n));
    endfunction

    task automatic sclk_cycle(input logic lr, input logic d);
        lrclk = lr;
        sdin  = d;
        repeat (hp) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (hp) @(posedge clk);
        #1 sclk = 1'b0;
    endtask

    // Philips format: slot data lags LRCLK by one bit clock.
    task automatic send_slot(input logic c, input logic [63:0] raw, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 0) sclk_cycle(c, pend);
            else        sclk_cycle(c, raw[n-i]);
        end
        pend = raw[0];
    endtask

    task automatic send_frame(input logic [63:0] lraw, input int ln,
                              input logic [63:0] rraw, input int rn, input bit emit);
        logic [W-1:0] lw;
        send_slot(1'b0, lraw, ln);
        send_slot(1'b1, rraw, rn);
        if (emit) begin
            lw = exp_word(lraw, ln);
            if ($signed(lw) > TH)       m_ear = 1'b1;
            else if ($signed(lw) < -TH) m_ear = 1'b0;
            e_l.push_back(lw);
            e_r.push_back(exp_word(rraw, rn));
            e_e.push_back(m_ear);
        end
    endtask

    task automatic close_frame();
        sclk_cycle(1'b0, pend);
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_l.delete(); q_r.delete(); q_e.delete();
        e_l.delete(); e_r.delete(); e_e.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; sclk = 1'b0; lrclk = 1'b0; sdin = 1'b0; pend = 1'b0; m_ear = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        clear_q();
    endtask

    task automatic compare_all(input string tag);
        int n;
        check({tag, "_count"}, 64'(q_l.size()), 64'(e_l.size()));
        n = (q_l.size() < e_l.size()) ? q_l.size() : e_l.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_left%0d", tag, i),  64'(q_l[i]), 64'(e_l[i]));
            check($sformatf("%s_right%0d", tag, i), 64'(q_r[i]), 64'(e_r[i]));
            check($sformatf("%s_ear%0d", tag, i),   64'(q_e[i]), 64'(e_e[i]));
        end
        clear_q();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_left"},  64'($unsigned(left)), 64'd0);
        check({tag, "_right"}, 64'($unsigned(right)), 64'd0);
        check({tag, "_valid"}, {63'd0, sv}, 64'd0);
        check({tag, "_ear"},   {63'd0, ear}, 64'd0);
        check({tag, "_ferr"},  {63'd0, ferr}, 64'd0);
    endtask

    initial begin
        logic [63:0] lr_raw, rr_raw;
        int          ln, rn;
        int          ear_vals[5];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        do_reset();

        // Two 32-bit frames at clk/8: the first is consumed by synchronisation
        hp = 4;
        send_frame({16'h1234, 16'h5A5A}, 32, {16'hABCD, 16'h0F0F}, 32, 1'b0);
        send_frame({16'h1234, 16'h5A5A}, 32, {16'hABCD, 16'h0F0F}, 32, 1'b1);
        close_frame();
        compare_all("frame32");
        check("frame32_ferr", {63'd0, ferr}, 64'd0);

        // 24-bit slots: extra LSBs dropped
        do_reset();
        hp = 2;
        send_frame(64'($urandom), 24, 64'($urandom), 24, 1'b0);
        send_frame(64'h7FFF00, 24, 64'h123456, 24, 1'b1);
        close_frame();
        compare_all("slot24");

        // 12-bit slots: LSBs zero-padded
        do_reset();
        hp = 3;
        send_frame(64'h321, 12, 64'h654, 12, 1'b0);
        send_frame(64'hABC, 12, 64'h5A5, 12, 1'b1);
        close_frame();
        compare_all("slot12");

        // EAR hysteresis: +600, +100, -100, -600, -100
        do_reset();
        hp = 2;
        ear_vals = '{600, 100, -100, -600, -100};
        send_frame(64'd0, 32, 64'd0, 32, 1'b0);
        foreach (ear_vals[i])
            send_frame({32'd0, 16'(ear_vals[i]), 16'h0000}, 32, 64'($urandom), 32, 1'b1);
        close_frame();
        compare_all("ear");
        check("ear_final", {63'd0, ear}, 64'd0);

        // Overrun: LRCLK low for 70 bit clocks
        do_reset();
        hp = 2;
        send_frame(64'($urandom), 32, 64'($urandom), 32, 1'b0);
        for (int i = 0; i < 70; i++) sclk_cycle(1'b0, 1'($urandom));
        repeat (12) @(posedge clk);
        #1;
        check("overrun_ferr", {63'd0, ferr}, 64'd1);
        compare_all("overrun_nosample");
        send_frame(64'($urandom), 32, 64'($urandom), 32, 1'b0);
        send_frame({16'h4321, 16'h0000}, 32, {16'h8001, 16'hFFFF}, 32, 1'b1);
        close_frame();
        compare_all("after_overrun");
        check("after_overrun_ferr", {63'd0, ferr}, 64'd1);

        // Reset in the middle of a right slot
        send_slot(1'b0, 64'($urandom), 32);
        for (int i = 0; i < 10; i++) sclk_cycle(1'b1, 1'($urandom));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midreset");
        rst = 1'b0;
        m_ear = 1'b0;
        clear_q();
        for (int i = 0; i < 22; i++) sclk_cycle(1'b1, 1'($urandom));
        send_slot(1'b0, 64'($urandom), 32);
        for (int i = 0; i < 8; i++) sclk_cycle(1'b1, 1'($urandom));
        repeat (12) @(posedge clk);
        #1;
        compare_all("midreset_partial");

        // Random frames, random slot lengths and bit-clock rates
        for (int r = 0; r < 2; r++) begin
            do_reset();
            hp = $urandom_range(2, 6);
            for (int f = 0; f < 8; f++) begin
                ln = $urandom_range(8, 40);
                rn = $urandom_range(8, 40);
                lr_raw = {$urandom, $urandom};
                rr_raw = {$urandom, $urandom};
                send_frame(lr_raw, ln, rr_raw, rn, f > 0);
            end
            close_frame();
            compare_all($sformatf("random%0d", r));
            check($sformatf("random%0d_ferr", r), {63'd0, ferr}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
